// File: rtl/btb_set_assoc.sv
// Set-associative branch target buffer with per-set LRU ages and a registered lookup response.
// Define BTB_STATS_EN to build the saturating lookup/hit statistics counters.
module btb_set_assoc #(
    parameter int ADDR_W = 32,
    parameter int SETS   = 8,
    parameter int WAYS   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lookup_valid,
    input  logic [ADDR_W-1:0] lookup_pc,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              flush,
    output logic              resp_valid,
    output logic              hit,
    output logic [ADDR_W-1:0] target_address,
    output logic [15:0]       lookup_cnt,
    output logic [15:0]       hit_cnt
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef logic [WAY_W-1:0]            way_t;
    typedef logic [WAYS-1:0][WAY_W-1:0]  age_vec_t;

    logic [WAYS-1:0]   valid_q [SETS];
    age_vec_t          age_q   [SETS];
    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic [ADDR_W-1:0] tgt_q   [SETS][WAYS];

    function automatic age_vec_t ages_reset();
        age_vec_t r;
        for (int w = 0; w < WAYS; w++) begin
            r[w] = way_t'(w);
        end
        return r;
    endfunction

    function automatic way_t lowest_set(logic [WAYS-1:0] v);
        way_t r;
        r = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (v[w]) r = way_t'(w);
        end
        return r;
    endfunction

    function automatic way_t lru_way(age_vec_t a);
        way_t r;
        r = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (a[w] == way_t'(WAYS - 1)) r = way_t'(w);
        end
        return r;
    endfunction

    // Accessed way becomes youngest; only ways younger than it age, so ages stay a permutation.
    function automatic age_vec_t touch(age_vec_t a, way_t way);
        age_vec_t r;
        r = a;
        for (int w = 0; w < WAYS; w++) begin
            if (way_t'(w) == way) r[w] = '0;
            else if (a[w] < a[way]) r[w] = a[w] + way_t'(1);
        end
        return r;
    endfunction

    logic [IDX_W-1:0]  lk_idx, up_idx;
    logic [TAG_W-1:0]  lk_tag, up_tag;
    logic [WAYS-1:0]   lk_match, up_match;
    way_t              lk_way, up_way;
    logic              lk_hit, up_en;
    logic [ADDR_W-1:0] lk_target;
    age_vec_t          up_age_base, up_age_new;

    assign lk_idx = lookup_pc[IDX_W-1:0];
    assign lk_tag = lookup_pc[ADDR_W-1:IDX_W];
    assign up_idx = upd_pc[IDX_W-1:0];
    assign up_tag = upd_pc[ADDR_W-1:IDX_W];

    always_comb begin
        lk_match = '0;
        up_match = '0;
        for (int w = 0; w < WAYS; w++) begin
            lk_match[w] = valid_q[lk_idx][w] && (tag_q[lk_idx][w] == lk_tag);
            up_match[w] = valid_q[up_idx][w] && (tag_q[up_idx][w] == up_tag);
        end
    end

    // The update sees the ages after a same-cycle lookup hit has touched its set.
    always_comb begin
        lk_way    = lowest_set(lk_match);
        lk_hit    = lookup_valid && !flush && (|lk_match);
        lk_target = tgt_q[lk_idx][lk_way];
        up_en     = upd_valid && !flush;
        if (lk_hit && (lk_idx == up_idx)) up_age_base = touch(age_q[lk_idx], lk_way);
        else                              up_age_base = age_q[up_idx];
        if (|up_match)                up_way = lowest_set(up_match);
        else if (~&valid_q[up_idx])   up_way = lowest_set(~valid_q[up_idx]);
        else                          up_way = lru_way(up_age_base);
        up_age_new = touch(up_age_base, up_way);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                age_q[s]   <= ages_reset();
            end
        end else if (flush) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                age_q[s]   <= ages_reset();
            end
        end else begin
            if (lk_hit) age_q[lk_idx] <= touch(age_q[lk_idx], lk_way);
            if (up_en) begin
                age_q[up_idx]           <= up_age_new;
                valid_q[up_idx][up_way] <= 1'b1;
            end
        end
    end

    // Tag and target storage carries no reset; valid bits alone qualify hits.
    always_ff @(posedge clk) begin
        if (up_en) begin
            tag_q[up_idx][up_way] <= up_tag;
            tgt_q[up_idx][up_way] <= upd_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid     <= 1'b0;
            hit            <= 1'b0;
            target_address <= '0;
        end else begin
            resp_valid     <= lookup_valid;
            hit            <= lk_hit;
            target_address <= lk_hit ? lk_target : '0;
        end
    end

`ifdef BTB_STATS_EN
    logic [15:0] lookup_cnt_q, hit_cnt_q;

    // Counts responses as they are presented; a flush at the same edge wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lookup_cnt_q <= '0;
            hit_cnt_q    <= '0;
        end else if (flush) begin
            lookup_cnt_q <= '0;
            hit_cnt_q    <= '0;
        end else if (resp_valid) begin
            if (lookup_cnt_q != 16'hFFFF) lookup_cnt_q <= lookup_cnt_q + 16'd1;
            if (hit && (hit_cnt_q != 16'hFFFF)) hit_cnt_q <= hit_cnt_q + 16'd1;
        end
    end

    assign lookup_cnt = lookup_cnt_q;
    assign hit_cnt    = hit_cnt_q;
`else
    assign lookup_cnt = '0;
    assign hit_cnt    = '0;
`endif

endmodule

// File: tb/tb_btb_set_assoc.sv
// Scoreboard bench for btb_set_assoc (SETS=8, WAYS=2, ADDR_W=32) with directed vectors.
module tb_btb_set_assoc;
`ifdef BTB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lookup_valid;
    logic [31:0] lookup_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        flush;
    logic        resp_valid;
    logic        hit;
    logic [31:0] target_address;
    logic [15:0] lookup_cnt;
    logic [15:0] hit_cnt;

    btb_set_assoc #(.ADDR_W(32), .SETS(8), .WAYS(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
        .flush(flush),
        .resp_valid(resp_valid), .hit(hit), .target_address(target_address),
        .lookup_cnt(lookup_cnt), .hit_cnt(hit_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic        h;
        logic [31:0] t;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_lk  = 0;
    int   n_hit = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic expect_resp(input logic [31:0] pc, input logic h, input logic [31:0] t);
        q.push_back('{pc: pc, h: h, t: t});
        n_lk++;
        if (h) n_hit++;
    endtask

    task automatic lookup(input logic [31:0] pc, input logic h, input logic [31:0] t);
        expect_resp(pc, h, t);
        lookup_valid = 1'b1;
        lookup_pc    = pc;
        cycle();
        lookup_valid = 1'b0;
    endtask

    task automatic update(input logic [31:0] pc, input logic [31:0] t);
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_target = t;
        cycle();
        upd_valid  = 1'b0;
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_lookup_cnt"}, {16'd0, lookup_cnt}, STATS ? 32'(n_lk) : 32'd0);
        check({tag, "_hit_cnt"}, {16'd0, hit_cnt}, STATS ? 32'(n_hit) : 32'd0);
    endtask

    // Monitor: every presented response is matched against the oldest expectation.
    always @(negedge clk) begin
        if (resp_valid) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_resp: resp_valid=1 hit=%0b target=%h, expected no response", hit, target_address);
            end else begin
                exp_t e;
                e = q.pop_front();
                check($sformatf("hit_pc_%h", e.pc), {31'd0, hit}, {31'd0, e.h});
                check($sformatf("target_pc_%h", e.pc), target_address, e.t);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; lookup_valid = 1'b0; lookup_pc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_target = '0; flush = 1'b0;
        @(negedge clk);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_hit", {31'd0, hit}, 32'd0);
        check("rst_target", target_address, 32'd0);
        check("rst_lookup_cnt", {16'd0, lookup_cnt}, 32'd0);
        check("rst_hit_cnt", {16'd0, hit_cnt}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cycle();

        // Cold miss, then install and hit; same set with a different tag misses.
        lookup(32'h104, 1'b0, 32'h0);
        update(32'h104, 32'h200);
        lookup(32'h104, 1'b1, 32'h200);
        lookup(32'h204, 1'b0, 32'h0);
        idle(2);
        check_counts("cnt_a");

        // Overwrite in place, fill set 4, refresh 0x104, then evict the LRU 0x204.
        update(32'h104, 32'h210);
        update(32'h204, 32'h220);
        lookup(32'h104, 1'b1, 32'h210);
        update(32'h304, 32'h330);
        lookup(32'h204, 1'b0, 32'h0);
        lookup(32'h104, 1'b1, 32'h210);
        lookup(32'h304, 1'b1, 32'h330);
        idle(2);
        check_counts("cnt_b");

        // Empty the BTB, then same-cycle lookup and install of 0x10C.
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        n_lk = 0; n_hit = 0;
        check_counts("cnt_flush1");
        expect_resp(32'h10C, 1'b0, 32'h0);
        lookup_valid = 1'b1; lookup_pc = 32'h10C;
        upd_valid = 1'b1; upd_pc = 32'h10C; upd_target = 32'h500;
        cycle();
        lookup_valid = 1'b0; upd_valid = 1'b0;
        lookup(32'h10C, 1'b1, 32'h500);

        // A same-cycle lookup hit refreshes 0x10C before the update picks its victim.
        update(32'h20C, 32'h600);
        expect_resp(32'h10C, 1'b1, 32'h500);
        lookup_valid = 1'b1; lookup_pc = 32'h10C;
        upd_valid = 1'b1; upd_pc = 32'h30C; upd_target = 32'h700;
        cycle();
        lookup_valid = 1'b0; upd_valid = 1'b0;
        lookup(32'h20C, 1'b0, 32'h0);
        lookup(32'h10C, 1'b1, 32'h500);
        lookup(32'h30C, 1'b1, 32'h700);
        idle(2);
        check_counts("cnt_c");

        // Flush beats a simultaneous update; counters clear.
        flush = 1'b1; upd_valid = 1'b1; upd_pc = 32'h104; upd_target = 32'h777;
        cycle();
        flush = 1'b0; upd_valid = 1'b0;
        n_lk = 0; n_hit = 0;
        check_counts("cnt_flush2");
        lookup(32'h104, 1'b0, 32'h0);

        // A lookup coincident with a flush responds as a miss.
        update(32'h104, 32'h900);
        idle(1);
        n_lk = 0; n_hit = 0;
        expect_resp(32'h104, 1'b0, 32'h0);
        flush = 1'b1; lookup_valid = 1'b1; lookup_pc = 32'h104;
        cycle();
        flush = 1'b0; lookup_valid = 1'b0;
        lookup(32'h104, 1'b0, 32'h0);
        idle(2);
        check_counts("cnt_d");

        // Reset while a lookup is being requested: no response, entries gone.
        update(32'h104, 32'h100);
        lookup(32'h104, 1'b1, 32'h100);
        idle(2);
        lookup_valid = 1'b1; lookup_pc = 32'h104;
        #3;
        rst_n = 1'b0;
        n_lk = 0; n_hit = 0;
        @(negedge clk);
        check("inrst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check_counts("cnt_inrst");
        @(posedge clk); #1;
        check("inrst_resp_valid2", {31'd0, resp_valid}, 32'd0);
        lookup_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("postrst_resp_valid", {31'd0, resp_valid}, 32'd0);
        @(posedge clk); #1;
        check("postrst_resp_valid2", {31'd0, resp_valid}, 32'd0);
        lookup(32'h104, 1'b0, 32'h0);
        lookup(32'h10C, 1'b0, 32'h0);
        idle(3);
        check("outstanding_responses", 32'(q.size()), 32'd0);
        check_counts("cnt_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/btb_set_assoc.md
BTB_SET_ASSOC -- requirements
Module: btb_set_assoc

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning PC and target width in bits.
REQ-002 SHALL have parameter SETS, default 8, meaning number of sets; power of two, >=2; IDX_W = log2(SETS).
REQ-003 SHALL have parameter WAYS, default 2, meaning entries per set; power of two, 1..8.
REQ-004 SHALL have port clk  input  1  meaning sole clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n  input  1  meaning asynchronous, active-low reset.
REQ-006 SHALL have port lookup_valid  input  1  meaning a lookup request this cycle.
REQ-007 SHALL have port lookup_pc  input  ADDR_W  meaning PC to look up.
REQ-008 SHALL have port upd_valid  input  1  meaning an install request this cycle.
REQ-009 SHALL have port upd_pc  input  ADDR_W  meaning branch PC to install.
REQ-010 SHALL have port upd_target  input  ADDR_W  meaning target for upd_pc.
REQ-011 SHALL have port flush  input  1  meaning invalidate all entries.
REQ-012 SHALL have port resp_valid  output  1  meaning the lookup response is valid.
REQ-013 SHALL have port hit  output  1  meaning the responded lookup matched.
REQ-014 SHALL have port target_address  output  ADDR_W  meaning target on hit; 0 on miss.
REQ-015 SHALL have port lookup_cnt  output  16  meaning lookups counted (see Configuration).
REQ-016 SHALL have port hit_cnt  output  16  meaning hits counted (see Configuration).

Function
REQ-017 SHALL split the PC as index = pc[IDX_W-1:0] and tag = pc[ADDR_W-1:IDX_W]; each entry holds valid, tag and target.
REQ-018 SHALL register the lookup response with 1-cycle latency: resp_valid in cycle N+1 equals lookup_valid in cycle N.
REQ-019 SHALL assert hit only when resp_valid=1 and a valid way in the indexed set holds the matching tag; otherwise hit=0 and target_address=0.
REQ-020 SHALL allocate an update in this priority: the way with a matching valid tag (overwrite); else the lowest-numbered invalid way; else the LRU way.
REQ-021 SHALL track LRU per set with an age of log2(WAYS) bits per way: the accessed way goes to age 0, and ways younger than it increment; ages stay a permutation of 0..WAYS-1.
REQ-022 SHALL count as an access both a lookup hit and an update; a lookup miss leaves ages unchanged.
REQ-023 SHALL, when a lookup and an update target the same set in the same cycle, make the lookup see the pre-update contents (read-before-write); the update is applied after the lookup's LRU touch.
REQ-024 SHALL, on flush=1, clear every valid bit and reset ages at that edge.
REQ-025 SHALL give flush priority over a simultaneous update (update dropped); a simultaneous lookup responds as a miss.
REQ-026 SHALL ignore upd_pc and upd_target when upd_valid=0, and lookup_pc when lookup_valid=0.

Reset
REQ-027 SHALL, while rst_n=0, force resp_valid=0, hit=0, target_address=0, lookup_cnt=0, hit_cnt=0, all valid bits=0, and set way w age=w in every set.
REQ-028 SHALL discard any lookup in flight when reset asserts mid-operation; no response appears after rst_n deasserts.
REQ-029 SHALL leave the tag and target arrays unreset; only the valid bits gate hits.

Configuration
REQ-030 SHALL compile the counters only when macro BTB_STATS_EN is defined: lookup_cnt increments on each resp_valid, and hit_cnt on each resp_valid with hit; both saturate at 16'hFFFF and clear on flush.
REQ-031 SHALL, without BTB_STATS_EN, tie lookup_cnt and hit_cnt to 0 and instantiate no counter logic.

Verification (SETS=8, WAYS=2, ADDR_W=32, BTB_STATS_EN defined)
REQ-032 SHALL cover: reset, then lookup 0x00000104 -> next cycle resp_valid=1, hit=0, target_address=0.
REQ-033 SHALL cover: update pc 0x00000104 / target 0x00000200, then lookup 0x00000104 -> hit=1, target 0x00000200; lookup 0x00000204 (same set 4, different tag) -> hit=0.
REQ-034 SHALL cover: install 0x104, 0x204, look up 0x104 (hit), then install 0x304 -> 0x204 is evicted (miss); 0x104 and 0x304 hit.
REQ-035 SHALL cover: same-cycle lookup 0x10C and update 0x10C -> 0x500 on an empty BTB -> response hit=0; the next lookup gives hit=1, target 0x500.
REQ-036 SHALL cover: flush and update 0x104 in the same cycle -> subsequent lookup 0x104 misses; lookup_cnt and hit_cnt read 0 after the flush.
REQ-037 SHALL cover: rst_n low while lookup_valid=1 -> resp_valid stays 0 through reset and the following cycle; all prior entries miss.
